feistel_xor_stage: RTL and testbench

//  Parametrised, pipelined Feistel round-combine stage for the DES datapath.

---
 rtl/feistel_xor_stage_if.sv | 31 +++
 rtl/feistel_xor_stage.sv | 99 +++++++++
 tb/tb_feistel_xor_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/feistel_xor_stage_if.sv
// Handshake/data bundle for the Feistel round-combine stage.
//   Upstream side : inValid, inReady, leftHalf, rightHalf, fOutput, lastRound
//   Downstream side: outValid, outReady, outLeft, outRight, outCount
// slave  = the stage itself; master = whoever drives it (round controller / bench).
interface feistel_xor_stage_if #(
  parameter int unsigned WIDTH = 32
) ();
  localparam int unsigned CNT_W = 16;

  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] leftHalf;
  logic [WIDTH-1:0] rightHalf;
  logic [WIDTH-1:0] fOutput;
  logic             lastRound;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outLeft;
  logic [WIDTH-1:0] outRight;
  logic [CNT_W-1:0] outCount;

  modport slave (
    input  inValid, leftHalf, rightHalf, fOutput, lastRound, outReady,
    output inReady, outValid, outLeft, outRight, outCount
  );

  modport master (
    output inValid, leftHalf, rightHalf, fOutput, lastRound, outReady,
    input  inReady, outValid, outLeft, outRight, outCount
  );
endinterface

// File: rtl/feistel_xor_stage.sv
// Pipelined Feistel round-combine: x = L ^ f, then half-swap (skipped on the
// last round), carried through a DEPTH-stage elastic valid/ready pipeline.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   flush  : synchronous clear of every in-flight beat
//   bus    : feistel_xor_stage_if.slave (input beat, output beat, delivered count)
module feistel_xor_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  feistel_xor_stage_if.slave  bus
);
  localparam int unsigned BW    = 2 * WIDTH;
  localparam int unsigned CNT_W = 16;

  logic [DEPTH-1:0] v_q, v_d;
  logic [BW-1:0]    data_q [DEPTH];
  logic [BW-1:0]    data_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] x;
  logic [BW-1:0]    comb;
  logic             out_fire;

  // Round combine; packed as {L, R}
  always_comb begin
    x    = bus.leftHalf ^ bus.fOutput;
    comb = bus.lastRound ? {x, bus.rightHalf} : {bus.rightHalf, x};
  end

  // Stage k may advance if downstream accepts or any stage from k to the end
  // holds a bubble; written without a chained vector to keep it flat.
  always_comb begin
    logic        any_empty;
    int unsigned idx;
    any_empty = 1'b0;
    rdy       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx       = DEPTH - 1 - i;
      any_empty = any_empty | ~v_q[idx];
      rdy[idx]  = bus.outReady | any_empty;
    end
  end

  assign out_fire = v_q[DEPTH-1] & bus.outReady;

  // Next state: flush wins; data regs only load on a valid beat
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (flush) begin
      v_d = '0;
    end else begin
      if (out_fire && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (rdy[0]) begin
        v_d[0] = bus.inValid;
        if (bus.inValid) begin
          data_d[0] = comb;
        end
      end
      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) begin
            data_d[k] = data_q[k-1];
          end
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      v_q    <= v_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  assign bus.inReady  = rdy[0];
  assign bus.outValid = v_q[DEPTH-1];
  assign bus.outLeft  = data_q[DEPTH-1][BW-1:WIDTH];
  assign bus.outRight = data_q[DEPTH-1][WIDTH-1:0];
  assign bus.outCount = cnt_q;
endmodule

// File: tb/tb_feistel_xor_stage.sv
// Bench for feistel_xor_stage: three instances (32/2, 8/1, 8/4) share one
// stimulus stream; a queue-based model checks every cycle, directed vectors
// pin literal results, latency, stall, flush and reset behaviour.
module tb_feistel_xor_stage;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        last = 1'b0;
  logic [31:0] l_in = '0;
  logic [31:0] r_in = '0;
  logic [31:0] f_in = '0;

  always #5 clk = ~clk;

  feistel_xor_stage_if #(.WIDTH(32)) bus0 ();
  feistel_xor_stage_if #(.WIDTH(8))  bus1 ();
  feistel_xor_stage_if #(.WIDTH(8))  bus2 ();

  assign bus0.inValid = in_valid;   assign bus1.inValid = in_valid;   assign bus2.inValid = in_valid;
  assign bus0.outReady = out_ready; assign bus1.outReady = out_ready; assign bus2.outReady = out_ready;
  assign bus0.lastRound = last;     assign bus1.lastRound = last;     assign bus2.lastRound = last;
  assign bus0.leftHalf = l_in;      assign bus1.leftHalf = l_in[7:0]; assign bus2.leftHalf = l_in[7:0];
  assign bus0.rightHalf = r_in;     assign bus1.rightHalf = r_in[7:0]; assign bus2.rightHalf = r_in[7:0];
  assign bus0.fOutput = f_in;       assign bus1.fOutput = f_in[7:0];  assign bus2.fOutput = f_in[7:0];

  feistel_xor_stage #(.WIDTH(32), .DEPTH(2)) dut0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0));
  feistel_xor_stage #(.WIDTH(8),  .DEPTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1));
  feistel_xor_stage #(.WIDTH(8),  .DEPTH(4)) dut2 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2));

  logic        ov  [NI];
  logic        ir  [NI];
  logic [31:0] ol  [NI];
  logic [31:0] orr [NI];
  logic [15:0] oc  [NI];

  assign ov[0] = bus0.outValid; assign ir[0] = bus0.inReady;
  assign ol[0] = bus0.outLeft;  assign orr[0] = bus0.outRight; assign oc[0] = bus0.outCount;
  assign ov[1] = bus1.outValid; assign ir[1] = bus1.inReady;
  assign ol[1] = 32'(bus1.outLeft); assign orr[1] = 32'(bus1.outRight); assign oc[1] = bus1.outCount;
  assign ov[2] = bus2.outValid; assign ir[2] = bus2.inReady;
  assign ol[2] = 32'(bus2.outLeft); assign orr[2] = 32'(bus2.outRight); assign oc[2] = bus2.outCount;

  int n_checks = 0;
  int n_fail   = 0;
  int rst_pulses = 0;

  // model state
  logic [63:0] sbq [NI][$];
  logic [15:0] m_cnt [NI];
  logic        stall_prev [NI];
  logic [63:0] held [NI];
  int          seen_rst = 0;

  function automatic int wid(input int i);
    return (i == 0) ? 32 : 8;
  endfunction

  function automatic int dep(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  // Reference combine: L' = R, R' = L^f, or no swap on the last round
  function automatic logic [63:0] combine(input logic [31:0] l, input logic [31:0] r,
                                          input logic [31:0] f, input logic lr, input int w);
    logic [31:0] m, xx, rr;
    m  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xx = (l ^ f) & m;
    rr = r & m;
    return lr ? {xx, rr} : {rr, xx};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the queue model, then advance the model
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n || (rst_pulses != seen_rst)) begin
        seen_rst = rst_pulses;
        for (int i = 0; i < NI; i++) begin
          sbq[i].delete();
          m_cnt[i] = '0;
          stall_prev[i] = 1'b0;
          held[i] = '0;
        end
      end
      if (rst_n) begin
        for (int i = 0; i < NI; i++) begin
          check($sformatf("i%0d_count", i), 64'(oc[i]), 64'(m_cnt[i]));
          check($sformatf("i%0d_inready", i), 64'(ir[i]),
                64'((sbq[i].size() < dep(i)) || out_ready));
          if (stall_prev[i]) begin
            check($sformatf("i%0d_stall_valid", i), 64'(ov[i]), 64'(1));
            check($sformatf("i%0d_stall_data", i), {ol[i], orr[i]}, held[i]);
          end
          if (ov[i]) begin
            check($sformatf("i%0d_valid_pending", i), 64'(sbq[i].size() > 0), 64'(1));
            if (sbq[i].size() > 0)
              check($sformatf("i%0d_out_data", i), {ol[i], orr[i]}, sbq[i][0]);
          end
          if (flush) begin
            sbq[i].delete();
            stall_prev[i] = 1'b0;
          end else begin
            if (ov[i] && out_ready) begin
              if (sbq[i].size() > 0) void'(sbq[i].pop_front());
              if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
            end
            if (in_valid && ir[i])
              sbq[i].push_back(combine(l_in, r_in, f_in, last, wid(i)));
            stall_prev[i] = ov[i] && !out_ready;
            held[i] = {ol[i], orr[i]};
          end
        end
      end
    end
  endtask

  // One beat with outReady high; checks 2-cycle latency and literal result on instance 0
  task automatic one_beat(input logic [31:0] l, input logic [31:0] r, input logic [31:0] f,
                          input logic lr, input logic [63:0] exp, input logic [15:0] exp_cnt,
                          input string tag);
    out_ready = 1'b1;
    l_in = l; r_in = r; f_in = f; last = lr; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_not_early"}, 64'(ov[0]), 64'(0));
    tick();
    check({tag, "_valid"}, 64'(ov[0]), 64'(1));
    check({tag, "_data"}, {ol[0], orr[0]}, exp);
    tick();
    check({tag, "_count"}, 64'(oc[0]), 64'(exp_cnt));
    repeat (5) tick();
  endtask

  task automatic set_beat(input int n);
    l_in = 32'h1000_0000 + 32'(n);
    r_in = 32'h2000_0000 + 32'(n * 3);
    f_in = 32'h0F0F_00A5 ^ 32'(n * 7);
    last = n[0];
  endtask

  initial begin
    int idx;
    int guard;
    logic fire;
    int lat [NI];
    int vcnt [NI];

    fork
      monitor();
    join_none

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("i%0d_rst_valid", i), 64'(ov[i]), 64'(0));
      check($sformatf("i%0d_rst_count", i), 64'(oc[i]), 64'(0));
      check($sformatf("i%0d_rst_data", i), {ol[i], orr[i]}, 64'(0));
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NI; i++)
      check($sformatf("i%0d_rel_inready", i), 64'(ir[i]), 64'(1));

    // literal vectors
    one_beat(32'hFFFF0000, 32'h12345678, 32'h0F0F0F0F, 1'b0, 64'h12345678_F0F00F0F, 16'd1, "t1");
    one_beat(32'hFFFF0000, 32'h12345678, 32'h0F0F0F0F, 1'b1, 64'hF0F00F0F_12345678, 16'd2, "t2");
    one_beat(32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5, 1'b1, 64'h0, 16'd3, "t3");

    // stall: 6 beats, outReady low for 4 cycles
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      set_beat(idx); in_valid = 1'b1;
      @(negedge clk); fire = ir[0];
      tick();
      if (fire) idx++;
    end
    check("t4_accepts", 64'(idx), 64'(2));
    check("t4_inready_full", 64'(ir[0]), 64'(0));
    check("t4_stall_valid", 64'(ov[0]), 64'(1));
    out_ready = 1'b1;
    guard = 0;
    while (idx < 6 && guard < 50) begin
      set_beat(idx); in_valid = 1'b1;
      @(negedge clk); fire = ir[0];
      tick();
      if (fire) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check("t4_drive_bound", 64'(guard < 50), 64'(1));
    repeat (8) tick();
    check("t4_count", 64'(oc[0]), 64'(9));

    // 100 back-to-back beats
    for (int i = 0; i < NI; i++) begin lat[i] = 0; vcnt[i] = 0; end
    out_ready = 1'b1;
    for (int c = 0; c < 110; c++) begin
      if (c < 100) begin set_beat(c + 40); in_valid = 1'b1; end
      else in_valid = 1'b0;
      tick();
      for (int i = 0; i < NI; i++) begin
        if (ov[i]) begin
          vcnt[i]++;
          if (lat[i] == 0) lat[i] = c + 1;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      check($sformatf("t5_i%0d_latency", i), 64'(lat[i]), 64'(dep(i)));
      check($sformatf("t5_i%0d_valid_cycles", i), 64'(vcnt[i]), 64'(100));
    end
    check("t5_count", 64'(oc[0]), 64'(109));

    // async reset with two beats in flight
    out_ready = 1'b0;
    set_beat(200); in_valid = 1'b1; tick();
    set_beat(201); tick();
    in_valid = 1'b0;
    #1 rst_n = 1'b0; rst_pulses++;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("t6_i%0d_rst_valid", i), 64'(ov[i]), 64'(0));
      check($sformatf("t6_i%0d_rst_count", i), 64'(oc[i]), 64'(0));
      check($sformatf("t6_i%0d_rst_data", i), {ol[i], orr[i]}, 64'(0));
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int i = 0; i < NI; i++)
        check($sformatf("t6_i%0d_no_stale", i), 64'(ov[i]), 64'(0));
    end

    // flush with beats in flight and a beat offered in the flush cycle
    one_beat(32'hFFFF0000, 32'h12345678, 32'h0F0F0F0F, 1'b0, 64'h12345678_F0F00F0F, 16'd1, "t7");
    out_ready = 1'b0;
    set_beat(300); in_valid = 1'b1; tick();
    set_beat(301); tick();
    set_beat(302); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < NI; i++)
      check($sformatf("t7_i%0d_flush_valid", i), 64'(ov[i]), 64'(0));
    check("t7_flush_count", 64'(oc[0]), 64'(1));
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int i = 0; i < NI; i++)
        check($sformatf("t7_i%0d_discarded", i), 64'(ov[i]), 64'(0));
    end
    check("t7_count_after", 64'(oc[0]), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
